riscv_tpr_ctrl: RTL
===================

// Module: riscv_tpr_ctrl
// PURPOSE
//   Owns the Tag Propagation Register (TPR): one ALU_MODE_WIDTH field per instruction class.
//   Drives the operator_i input of riscv_alu_tag from the committed field for the class in EX.
//   Buffers CSR writes in a shadow register and commits them only on an EX instruction boundary,
//   so no in-flight instruction sees a mode change. Counts tagged results.
// PARAMETERS
//   NUM_CLASSES  8                    number of instruction classes (TPR fields)
//   CLS_W        $clog2(NUM_CLASSES)  width of class index
//   TPR_W        NUM_CLASSES*ALU_MODE_WIDTH  TPR width; field k = bits [k*ALU_MODE_WIDTH +: ALU_MODE_WIDTH]
//   TPR_RESET    '0                   TPR reset value; all fields ALU_MODE_OLD when that encoding is 0
//   CNT_WIDTH    16                   tagged-result counter width
// PORTS
//   clk             in   1               core clock
//   rst_n           in   1               asynchronous active-low reset
//   csr_we_i        in   1               CSR write strobe for TPR
//   csr_wdata_i     in   TPR_W           CSR write data
//   csr_rdata_o     out  TPR_W           TPR read value (shadow if pending, else committed)
//   csr_busy_o      out  1               update pending, not yet committed
//   ex_valid_i      in   1               instruction present in EX
//   ex_ready_i      in   1               EX instruction completes this cycle
//   ex_class_i      in   CLS_W           class of EX instruction
//   flush_i         in   1               pipeline flush (EX killed)
//   result_tag_i    in   1               result_o from riscv_alu_tag
//   alu_operator_o  out  ALU_MODE_WIDTH  operator_i for riscv_alu_tag
//   cnt_clr_i       in   1               clear tagged-result counter
//   tag_cnt_o       out  CNT_WIDTH       saturating count of tagged results
// BEHAVIOUR
//   Reset (async, rst_n=0): tpr_q=shadow_q=TPR_RESET, state IDLE, cnt=0.
//     After reset: csr_busy_o=0, csr_rdata_o=TPR_RESET, tag_cnt_o=0.
//   alu_operator_o: combinational, field[ex_class_i] of tpr_q (committed value only).
//     ex_class_i >= NUM_CLASSES -> ALU_MODE_OLD.
//   Boundary = !ex_valid_i | (ex_valid_i & ex_ready_i) | flush_i.
//   FSM, two states:
//     IDLE:    csr_we_i -> shadow_q<=csr_wdata_i, go PENDING. No commit in the write cycle.
//     PENDING: csr_we_i -> shadow_q<=csr_wdata_i (last write wins); stay PENDING, even at a boundary.
//              else if boundary -> tpr_q<=shadow_q at that edge, go IDLE.
//              else hold.
//   The instruction completing at the commit edge uses the old tpr_q.
//   The next EX instruction uses the new value.
//   csr_busy_o = (state==PENDING), registered.
//   csr_rdata_o = PENDING ? shadow_q : tpr_q.
//   Counter:
//     inc = ex_valid_i & ex_ready_i & !flush_i & result_tag_i & (alu_operator_o != ALU_MODE_OLD).
//     cnt_clr_i has priority over inc: clear wins.
//     Saturates at all-ones; no wrap.
//   Reset mid-PENDING discards shadow_q: tpr_q returns to TPR_RESET.
//   No X on any output; result_tag_i is ignored when it is not counted.
// TESTING
//   1 Reset; ex_class_i=3 -> alu_operator_o = field 3 of TPR_RESET, busy=0, tag_cnt_o=0.
//   2 ex_valid_i=1, ex_ready_i=0 held; write field3=ALU_MODE_OR -> busy=1.
//     alu_operator_o stays old while stalled.
//     Cycle with ex_ready_i=1: old op that cycle, OR from the next cycle, busy=0.
//   3 Two writes 0x11 then 0x22 in back-to-back cycles under stall -> commit 0x22.
//     csr_rdata_o=0x22 while pending.
//   4 Write, then flush_i=1 with EX stalled -> commit at that edge, busy=0 next cycle.
//   5 Write, then rst_n=0 while PENDING -> tpr_q=TPR_RESET, busy=0.
//   6 Counter at 0xFFFE, three tagged AND completions -> 0xFFFF (saturates).
//     cnt_clr_i together with inc -> 0.

Source files
------------

// File: rtl/riscv_tpr_ctrl.sv
// Tag Propagation Register controller: per-class ALU tag mode with CSR writes deferred
// to an EX instruction boundary, plus a saturating count of tagged results.
module riscv_tpr_ctrl #(
  parameter int ALU_MODE_WIDTH = 2,
  parameter logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OLD = 2'd0,
  parameter int NUM_CLASSES = 8,
  parameter int CLS_W = $clog2(NUM_CLASSES),
  parameter int TPR_W = NUM_CLASSES * ALU_MODE_WIDTH,
  parameter logic [TPR_W-1:0] TPR_RESET = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csr_we_i,
  input  logic [TPR_W-1:0]          csr_wdata_i,
  output logic [TPR_W-1:0]          csr_rdata_o,
  output logic                      csr_busy_o,
  input  logic                      ex_valid_i,
  input  logic                      ex_ready_i,
  input  logic [CLS_W-1:0]          ex_class_i,
  input  logic                      flush_i,
  input  logic                      result_tag_i,
  output logic [ALU_MODE_WIDTH-1:0] alu_operator_o,
  input  logic                      cnt_clr_i,
  output logic [CNT_WIDTH-1:0]      tag_cnt_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_e;

  state_e                      state_r, state_s;
  logic [TPR_W-1:0]            tpr_r, tpr_s;
  logic [TPR_W-1:0]            shadow_r, shadow_s;
  logic [CNT_WIDTH-1:0]        cnt_r;
  logic [ALU_MODE_WIDTH-1:0]   op_s;
  logic                        boundary_s;
  logic                        inc_s;

  assign boundary_s = !ex_valid_i || (ex_valid_i && ex_ready_i) || flush_i;

  // State, committed TPR and shadow registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      tpr_r    <= TPR_RESET;
      shadow_r <= TPR_RESET;
    end else begin
      state_r  <= state_s;
      tpr_r    <= tpr_s;
      shadow_r <= shadow_s;
    end
  end

  // Next-state: a write in progress always wins over committing at a boundary
  always_comb begin
    state_s  = state_r;
    tpr_s    = tpr_r;
    shadow_s = shadow_r;
    case (state_r)
      IDLE: begin
        if (csr_we_i) begin
          shadow_s = csr_wdata_i;
          state_s  = PENDING;
        end else begin
          state_s  = IDLE;
        end
      end
      PENDING: begin
        if (csr_we_i) begin
          shadow_s = csr_wdata_i;
          state_s  = PENDING;
        end else if (boundary_s) begin
          tpr_s    = shadow_r;
          state_s  = IDLE;
        end else begin
          state_s  = PENDING;
        end
      end
      default: begin
        state_s  = IDLE;
      end
    endcase
  end

  // Field select from the committed TPR; out-of-range classes fall back to OLD
  always_comb begin
    op_s = ALU_MODE_OLD;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      op_s = (ex_class_i == CLS_W'(k)) ? tpr_r[k*ALU_MODE_WIDTH +: ALU_MODE_WIDTH] : op_s;
    end
  end

  assign inc_s = ex_valid_i && ex_ready_i && !flush_i && result_tag_i && (op_s != ALU_MODE_OLD);

  // Saturating tagged-result counter; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (cnt_clr_i) begin
      cnt_r <= '0;
    end else if (inc_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign alu_operator_o = op_s;
  assign csr_busy_o     = (state_r == PENDING);
  assign csr_rdata_o    = (state_r == PENDING) ? shadow_r : tpr_r;
  assign tag_cnt_o      = cnt_r;

endmodule
